lutram_fifo_level: RTL and testbench

Next-generation LUT-RAM FIFO with read latency 0 (first-word-fall-through): head entry always present on oRd while not empty. Adds a full-depth occupancy count, registered programmable almost-full/almost-empty thresholds, protected write/read with sticky overflow/underflow flags, and true full at pFifoDepth entries. Used as the small elastic buffer between pixel/command pipeline stages where the producer needs early back-pressure to cover its own read latency.

---
 rtl/lutram_fifo_level_pkg.sv | 23 ++
 rtl/lutram_fifo_level_lutram_sdp.sv | 32 +++
 rtl/lutram_fifo_level.sv | 125 ++++++++++++
 tb/tb_lutram_fifo_level.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lutram_fifo_level_pkg.sv
// Shared constants and helpers for the level-tracking LUT-RAM FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package lutram_fifo_level_pkg;

  // The almost-full threshold defaults to this many entries below depth.
  // That gives the producer room for two in-flight writes after it sees
  // back-pressure.
  localparam int cAlmostFullOffset   = 2;
  localparam int cAlmostEmptyDefault = 2;

  // Number of bits needed to address v entries, i.e. ceil(log2(v)).
  // Returns at least 1 so that degenerate sizes still produce legal vectors.
  function automatic int fBitWidth(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lutram_fifo_level_lutram_sdp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// Latency: write lands at the clock edge; read is combinational from address.
// Backpressure: none; the caller gates iWe.
//
// Ports:
//   iClk        write clock
//   iWe         write enable
//   iWa / iWd   write address / data
//   iRa / oRd   read address / combinational read data
module lutram_sdp #(
  parameter int pDepth = 16,
  parameter int pWidth = 8,
  parameter int pAw    = 4
) (
  input  logic              iClk,
  input  logic              iWe,
  input  logic [pAw-1:0]    iWa,
  input  logic [pWidth-1:0] iWd,
  input  logic [pAw-1:0]    iRa,
  output logic [pWidth-1:0] oRd
);

  // Contents are deliberately not reset so this maps onto LUT-RAM.
  logic [pWidth-1:0] mem [pDepth];

  always_ff @(posedge iClk) begin
    if (iWe) mem[iWa] <= iWd;
  end

  assign oRd = mem[iRa];

endmodule

// File: rtl/lutram_fifo_level.sv
// First-word-fall-through LUT-RAM FIFO with occupancy count, almost flags and sticky errors.
// Latency: write to oRd valid is 1 edge; pops expose the next head combinationally (0 latency).
// Backpressure: writes are refused when full unless a read pops in the same cycle; oAlmostFull gives early warning.
//
// Ports:
//   iClk, iRst             clock, synchronous active-high reset
//   iWd, iWe               write data / request
//   oFull, oAlmostFull     level == depth / level >= pAlmostFull
//   oRd, iRe               head entry (FWFT) / pop request
//   oEmp, oAlmostEmp       level == 0 / level <= pAlmostEmpty
//   oLevel                 occupancy 0..pFifoDepth
//   oOverflow, oUnderflow  sticky error flags, cleared by iErrClr
module lutram_fifo_level
  import lutram_fifo_level_pkg::*;
#(
  parameter int pFifoDepth    = 16,
  parameter int pFifoBitWidth = 8,
  parameter int pAlmostFull   = pFifoDepth - cAlmostFullOffset,
  parameter int pAlmostEmpty  = cAlmostEmptyDefault
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic [pFifoBitWidth-1:0]       iWd,
  input  logic                           iWe,
  output logic                           oFull,
  output logic                           oAlmostFull,
  output logic [pFifoBitWidth-1:0]       oRd,
  input  logic                           iRe,
  output logic                           oEmp,
  output logic                           oAlmostEmp,
  output logic [fBitWidth(pFifoDepth):0] oLevel,
  output logic                           oOverflow,
  output logic                           oUnderflow,
  input  logic                           iErrClr
);

  localparam int AW = fBitWidth(pFifoDepth);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] cAOne   = AW'(1);
  localparam logic [LW-1:0] cLOne   = LW'(1);
  localparam logic [LW-1:0] cLDepth = LW'(pFifoDepth);
  localparam logic [LW-1:0] cLAfTh  = LW'(pAlmostFull);
  localparam logic [LW-1:0] cLAeTh  = LW'(pAlmostEmpty);

  logic [AW-1:0] rWA;
  logic [AW-1:0] rRA;
  logic [LW-1:0] rLevel;
  logic [LW-1:0] wLevelNxt;
  logic          rFull;
  logic          rAlmostFull;
  logic          rEmp;
  logic          rAlmostEmp;
  logic          rOverflow;
  logic          rUnderflow;
  logic          wAcceptRd;
  logic          wAcceptWr;

  // Acceptance uses only registered flags, so there is no combinational
  // path from the flag outputs back into the accept logic.
  // A full FIFO can still take a write when a pop frees a slot in the same cycle.
  assign wAcceptRd = iRe & ~rEmp;
  assign wAcceptWr = iWe & (~rFull | wAcceptRd);

  always_comb begin
    wLevelNxt = rLevel;
    unique case ({wAcceptWr, wAcceptRd})
      2'b10:   wLevelNxt = rLevel + cLOne;
      2'b01:   wLevelNxt = rLevel - cLOne;
      default: wLevelNxt = rLevel;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rWA         <= '0;
      rRA         <= '0;
      rLevel      <= '0;
      rFull       <= 1'b0;
      rAlmostFull <= 1'b0;
      rEmp        <= 1'b1;
      rAlmostEmp  <= 1'b1;
      rOverflow   <= 1'b0;
      rUnderflow  <= 1'b0;
    end else begin
      if (wAcceptWr) rWA <= rWA + cAOne;
      if (wAcceptRd) rRA <= rRA + cAOne;
      rLevel <= wLevelNxt;
      // Flags are derived from the next level so they move on the same
      // edge as the transfer, not one cycle later.
      rFull       <= (wLevelNxt == cLDepth);
      rAlmostFull <= (wLevelNxt >= cLAfTh);
      rEmp        <= (wLevelNxt == '0);
      rAlmostEmp  <= (wLevelNxt <= cLAeTh);
      // A clear request wins over a new error in the same cycle.
      if (iErrClr)                 rOverflow <= 1'b0;
      else if (iWe & ~wAcceptWr)   rOverflow <= 1'b1;
      if (iErrClr)                 rUnderflow <= 1'b0;
      else if (iRe & rEmp)         rUnderflow <= 1'b1;
    end
  end

  // Writes are blocked during reset so a request in the reset cycle is dropped.
  lutram_sdp #(
    .pDepth (pFifoDepth),
    .pWidth (pFifoBitWidth),
    .pAw    (AW)
  ) uRam (
    .iClk (iClk),
    .iWe  (wAcceptWr & ~iRst),
    .iWa  (rWA),
    .iWd  (iWd),
    .iRa  (rRA),
    .oRd  (oRd)
  );

  assign oFull       = rFull;
  assign oAlmostFull = rAlmostFull;
  assign oEmp        = rEmp;
  assign oAlmostEmp  = rAlmostEmp;
  assign oLevel      = rLevel;
  assign oOverflow   = rOverflow;
  assign oUnderflow  = rUnderflow;

endmodule

// File: tb/tb_lutram_fifo_level.sv
// Directed self-checking bench for lutram_fifo_level (depth 16, width 8).
// Latency: n/a.
// Backpressure: n/a.
module tb_lutram_fifo_level;

  logic       iClk;
  logic       iRst;
  logic [7:0] iWd;
  logic       iWe;
  logic       oFull;
  logic       oAlmostFull;
  logic [7:0] oRd;
  logic       iRe;
  logic       oEmp;
  logic       oAlmostEmp;
  logic [4:0] oLevel;
  logic       oOverflow;
  logic       oUnderflow;
  logic       iErrClr;

  int nChecks;
  int nFails;

  logic [7:0] q[$];

  lutram_fifo_level #(
    .pFifoDepth    (16),
    .pFifoBitWidth (8),
    .pAlmostFull   (14),
    .pAlmostEmpty  (2)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iWd         (iWd),
    .iWe         (iWe),
    .oFull       (oFull),
    .oAlmostFull (oAlmostFull),
    .oRd         (oRd),
    .iRe         (iRe),
    .oEmp        (oEmp),
    .oAlmostEmp  (oAlmostEmp),
    .oLevel      (oLevel),
    .oOverflow   (oOverflow),
    .oUnderflow  (oUnderflow),
    .iErrClr     (iErrClr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkFlags(input string tag, input int lvl);
    checkVal({tag, "_lvl"}, 32'(oLevel), lvl);
    checkVal({tag, "_full"}, 32'(oFull), (lvl == 16) ? 1 : 0);
    checkVal({tag, "_af"}, 32'(oAlmostFull), (lvl >= 14) ? 1 : 0);
    checkVal({tag, "_emp"}, 32'(oEmp), (lvl == 0) ? 1 : 0);
    checkVal({tag, "_ae"}, 32'(oAlmostEmp), (lvl <= 2) ? 1 : 0);
  endtask

  initial begin
    logic       we;
    logic       re;
    logic [7:0] wd;

    nChecks = 0;
    nFails  = 0;
    iRst    = 1'b1;
    iWe     = 1'b0;
    iRe     = 1'b0;
    iWd     = '0;
    iErrClr = 1'b0;

    // Reset state.
    tick();
    tick();
    iRst = 1'b0;
    checkFlags("rst", 0);
    checkVal("rst_ovf", 32'(oOverflow), 0);
    checkVal("rst_udf", 32'(oUnderflow), 0);

    // Fill 0x00..0x0F: almost-full from the 14th write, full on the 16th.
    for (int i = 0; i < 16; i++) begin
      iWe = 1'b1;
      iWd = 8'(i);
      tick();
      checkFlags("fill", i + 1);
      if (i == 0) checkVal("fill_head", 32'(oRd), 0);
    end
    iWe = 1'b0;

    // Overflow at full: 0xAA is dropped, level holds, then clear.
    iWe = 1'b1;
    iWd = 8'hAA;
    tick();
    iWe = 1'b0;
    checkVal("ovf_set", 32'(oOverflow), 1);
    checkFlags("ovf", 16);
    iErrClr = 1'b1;
    tick();
    iErrClr = 1'b0;
    checkVal("ovf_clr", 32'(oOverflow), 0);

    // Drain: head must follow 0x00..0x0F cycle for cycle.
    for (int i = 0; i < 16; i++) begin
      checkVal("drain_rd", 32'(oRd), i);
      iRe = 1'b1;
      tick();
      checkFlags("drain", 15 - i);
    end
    iRe = 1'b0;
    checkVal("drain_udf", 32'(oUnderflow), 0);

    // Empty with write and read: read rejected, write taken.
    iWe = 1'b1;
    iRe = 1'b1;
    iWd = 8'h55;
    tick();
    iWe = 1'b0;
    iRe = 1'b0;
    checkVal("emp_both_udf", 32'(oUnderflow), 1);
    checkFlags("emp_both", 1);
    checkVal("emp_both_rd", 32'(oRd), 32'h55);
    iErrClr = 1'b1;
    tick();
    iErrClr = 1'b0;
    checkVal("udf_clr", 32'(oUnderflow), 0);

    // Refill to full with 0x60..0x6E behind 0x55.
    for (int i = 0; i < 15; i++) begin
      iWe = 1'b1;
      iWd = 8'(8'h60 + i);
      tick();
    end
    iWe = 1'b0;
    checkFlags("refill", 16);

    // Full with write and read: old head out, 0x77 in, level unchanged.
    checkVal("full_both_old", 32'(oRd), 32'h55);
    iWe = 1'b1;
    iRe = 1'b1;
    iWd = 8'h77;
    tick();
    iWe = 1'b0;
    iRe = 1'b0;
    checkFlags("full_both", 16);
    checkVal("full_both_ovf", 32'(oOverflow), 0);
    for (int i = 0; i < 16; i++) begin
      checkVal("full_drain_rd", 32'(oRd), (i < 15) ? (32'h60 + i) : 32'h77);
      iRe = 1'b1;
      tick();
    end
    iRe = 1'b0;
    checkFlags("full_drain", 0);

    // Interleaved random traffic against a queue model, level held to 3..12.
    // The bias toward running long makes the pointers wrap more than once.
    for (int i = 0; i < 3; i++) begin
      iWe = 1'b1;
      iWd = 8'(8'hC0 + i);
      tick();
      q.push_back(8'(8'hC0 + i));
    end
    iWe = 1'b0;
    for (int n = 0; n < 120; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wd = 8'($urandom_range(0, 255));
      if (q.size() >= 12) we = 1'b0;
      if (q.size() <= 3)  re = 1'b0;
      if (re) checkVal("wrap_rd", 32'(oRd), 32'(q[0]));
      iWe = we;
      iRe = re;
      iWd = wd;
      tick();
      iWe = 1'b0;
      iRe = 1'b0;
      if (re) void'(q.pop_front());
      if (we) q.push_back(wd);
      checkFlags("wrap", q.size());
    end

    // Bring the level to 7, then reset with a write request pending.
    for (int n = 0; n < 16 && q.size() > 7; n++) begin
      iRe = 1'b1;
      tick();
      void'(q.pop_front());
    end
    iRe = 1'b0;
    for (int n = 0; n < 16 && q.size() < 7; n++) begin
      iWe = 1'b1;
      iWd = 8'h11;
      tick();
      q.push_back(8'h11);
    end
    iWe = 1'b0;
    checkVal("pre_rst_lvl", 32'(oLevel), 7);
    iRst = 1'b1;
    iWe  = 1'b1;
    iWd  = 8'h99;
    tick();
    iRst = 1'b0;
    iWe  = 1'b0;
    q.delete();
    checkFlags("mid_rst", 0);
    iWe = 1'b1;
    iWd = 8'h33;
    tick();
    iWe = 1'b0;
    checkFlags("post_rst", 1);
    checkVal("post_rst_rd", 32'(oRd), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
